// File: rtl/fifo_pkg.sv
`default_nettype none
//============================================================
// Package : fifo_pkg -- fifo_gen2 status type and defaults
// Rev     : 1.0
//============================================================
package fifo_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_AE_LEVEL = 2;

    function automatic int def_af_level(input int depth);
        return depth - 2;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
//============================================================
// Module : fifo_mem -- simple dual-port RAM, registered read
// Rev    : 1.0
//============================================================
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array is deliberately not reset; pointer reset hides stale words.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a same-address write lands after this read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_gen2.sv
`default_nettype none
//============================================================
// Module : fifo_gen2 -- synchronous FIFO, registered flags
// Rev    : 1.0
//============================================================
module fifo_gen2
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = def_af_level(DEPTH),
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       WREN,
    input  logic                       RDEN,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    fifo_status_t  status;
    fifo_status_t  status_next;
    logic          rd_ok;
    logic          wr_ok;
    logic          ovf;
    logic          unf;

    assign rd_ok = RDEN && !status.empty;
    assign wr_ok = WREN && (!status.full || rd_ok);

    always_comb begin
        cnt_next = cnt;
        if (wr_ok && !rd_ok) begin
            cnt_next = cnt + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            cnt_next = cnt - CW'(1);
        end
    end

    // Flags decode the next count so they line up with count itself.
    always_comb begin
        status_next              = '0;
        status_next.full         = (cnt_next == CW'(DEPTH));
        status_next.empty        = (cnt_next == '0);
        status_next.almost_full  = (cnt_next >= CW'(AF_LEVEL));
        status_next.almost_empty = (cnt_next <= CW'(AE_LEVEL));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            status <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt    <= cnt_next;
            status <= status_next;
            // A new error event wins over a coincident clear.
            if (WREN && status.full && !rd_ok) begin
                ovf <= 1'b1;
            end else if (clr_err) begin
                ovf <= 1'b0;
            end
            if (RDEN && status.empty && !WREN) begin
                unf <= 1'b1;
            end else if (clr_err) begin
                unf <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign count        = cnt;
    assign overflow     = ovf;
    assign underflow    = unf;

endmodule
`default_nettype wire

// File: tb/tb_fifo_gen2.sv
`default_nettype none
//============================================================
// Module : tb_fifo_gen2 -- directed scoreboard bench for fifo_gen2
// Rev    : 1.0
//============================================================
module tb_fifo_gen2;

    logic       clk = 1'b0;
    logic       rst;
    logic       WREN;
    logic       RDEN;
    logic       clr_err;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic       rd_exp = 1'b0;

    fifo_gen2 #(
        .DATA_W   (8),
        .DEPTH    (16),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .WREN         (WREN),
        .RDEN         (RDEN),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_st(input string tag, input int cnt, input bit f, input bit e,
                          input bit af, input bit ae, input bit ov, input bit un);
        chk({tag, ".count"},        count,        cnt);
        chk({tag, ".full"},         full,         f);
        chk({tag, ".empty"},        empty,        e);
        chk({tag, ".almost_full"},  almost_full,  af);
        chk({tag, ".almost_empty"}, almost_empty, ae);
        chk({tag, ".overflow"},     overflow,     ov);
        chk({tag, ".underflow"},    underflow,    un);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; an accepted read queues its expected word.
    task automatic drive(input bit w, input bit r, input logic [7:0] d, input bit ce,
                         input bit rd_acc, input logic [7:0] exp_val);
        WREN    = w;
        RDEN    = r;
        data_in = d;
        clr_err = ce;
        rd_exp  = rd_acc;
        if (rd_acc) exp_q.push_back(exp_val);
        step();
        WREN    = 1'b0;
        RDEN    = 1'b0;
        data_in = 8'd0;
        clr_err = 1'b0;
        rd_exp  = 1'b0;
    endtask

    // Monitor: data_out is compared one cycle after each accepted read.
    always @(posedge clk) begin
        if (rd_exp) begin
            #2;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_read", 1, 0);
            end else begin
                chk("rd_data", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; WREN = 1'b0; RDEN = 1'b0; clr_err = 1'b0; data_in = 8'd0;
        #3 rst = 1'b0;
        step();
        chk_st("reset", 0, 0, 1, 0, 1, 0, 0);
        chk("reset.data_out", data_out, 0);
        rst = 1'b1;
        step();

        for (int i = 1; i <= 16; i++) begin
            drive(1, 0, 8'(i), 0, 0, 0);
            chk_st($sformatf("wr%0d", i), i, i == 16, 0, i >= 14, i <= 2, 0, 0);
        end

        drive(1, 0, 8'd77, 0, 0, 0);
        chk_st("ovf_set", 16, 1, 0, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("ovf_sticky", overflow, 1);
        drive(1, 0, 8'd55, 1, 0, 0);
        chk("ovf_set_beats_clr", overflow, 1);
        drive(0, 0, 0, 1, 0, 0);
        chk_st("ovf_clr", 16, 1, 0, 1, 0, 0, 0);

        drive(1, 1, 8'd99, 0, 1, 8'd1);
        chk_st("full_rw", 16, 1, 0, 1, 0, 0, 0);

        for (int k = 1; k <= 16; k++) begin
            drive(0, 1, 0, 0, 1, (k < 16) ? 8'(k + 1) : 8'd99);
            chk_st($sformatf("rd%0d", k), 16 - k, 0, k == 16, (16 - k) >= 14, (16 - k) <= 2, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("hold_data_out", data_out, 99);

        drive(0, 1, 0, 0, 0, 0);
        chk_st("unf_set", 0, 0, 1, 0, 1, 0, 1);
        chk("unf_hold_data_out", data_out, 99);
        drive(0, 1, 0, 1, 0, 0);
        chk("unf_set_beats_clr", underflow, 1);
        drive(0, 0, 0, 1, 0, 0);
        chk("unf_clr", underflow, 0);

        drive(1, 1, 8'd7, 0, 0, 0);
        chk_st("empty_rw", 1, 0, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 1, 8'd7);
        chk_st("empty_rw_rd", 0, 0, 1, 0, 1, 0, 0);

        for (int i = 0; i < 5; i++) drive(1, 0, 8'(10 + i), 0, 0, 0);
        chk("pre_rst.count", count, 5);
        #3 rst = 1'b0;
        #1;
        chk_st("async_rst", 0, 0, 1, 0, 1, 0, 0);
        chk("async_rst.data_out", data_out, 0);
        #2 rst = 1'b1;
        step();
        drive(1, 0, 8'd42, 0, 0, 0);
        chk("post_rst.count", count, 1);
        drive(0, 1, 0, 0, 1, 8'd42);
        chk("post_rst.empty", empty, 1);

        step();
        step();
        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_gen2.md
FIFO_GEN2 -- requirements
Module: fifo_gen2

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 16, entry count; power of two, 2..1024.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2; almost_full asserts when count >= AF_LEVEL.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2; almost_empty asserts when count <= AE_LEVEL.
REQ-005 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port WREN, input, 1, write request.
REQ-008 The block SHALL have port RDEN, input, 1, read request.
REQ-009 The block SHALL have port data_in, input, DATA_W, write data.
REQ-010 The block SHALL have port data_out, output, DATA_W, read data, registered.
REQ-011 The block SHALL have ports full, empty, almost_full and almost_empty, each output, 1, registered status flags.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH+1), current occupancy.
REQ-013 The block SHALL have ports overflow and underflow, each output, 1, sticky error flags.
REQ-014 The block SHALL have port clr_err, input, 1, synchronous clear of overflow and underflow.

Function
REQ-015 Read accepted (rd_ok) SHALL equal RDEN && !empty.
REQ-016 Write accepted (wr_ok) SHALL equal WREN && (!full || rd_ok); a write into a full FIFO alongside a read SHALL be accepted.
REQ-017 On wr_ok, data_in SHALL be written at wr_ptr, and wr_ptr SHALL increment modulo DEPTH.
REQ-018 On rd_ok, the entry at rd_ptr SHALL appear on data_out one cycle later, and rd_ptr SHALL increment modulo DEPTH.
REQ-019 data_out SHALL hold its last value when no read is accepted.
REQ-020 count SHALL update as +1 on wr_ok only, -1 on rd_ok only, and unchanged on both or neither.
REQ-021 full, empty, almost_full and almost_empty SHALL be registered and decoded from the next-cycle count, so they agree with count in the same cycle.
REQ-022 full SHALL equal (count == DEPTH), and empty SHALL equal (count == 0).
REQ-023 Simultaneous RDEN and WREN on an empty FIFO SHALL perform the write only; the read SHALL be ignored and SHALL NOT flag underflow.
REQ-024 overflow SHALL set when WREN && full && !rd_ok, and SHALL stay set until clr_err or reset.
REQ-025 underflow SHALL set when RDEN && empty && !WREN, and SHALL stay set until clr_err or reset.
REQ-026 When clr_err coincides with a new error event, the set SHALL take priority over the clear.
REQ-027 Memory contents and pointers SHALL never be altered by a rejected request.

Reset
REQ-028 While rst is low: wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, overflow=0, underflow=0, asynchronously.
REQ-029 Memory array contents SHALL NOT be reset; because of pointer reset, stale data SHALL never be readable.
REQ-030 Asserting reset mid-operation SHALL discard all stored entries; the first read after reset release SHALL return the first post-reset write.

Structure
REQ-031 Package fifo_pkg SHALL hold the status struct type (full, empty, almost_full, almost_empty) and the default-parameter constants.
REQ-032 Storage SHALL be a sub-module fifo_mem: a simple dual-port RAM with one synchronous write port and one synchronous read port, parameterised by DATA_W and DEPTH.
REQ-033 Pointer, count and flag logic SHALL reside in fifo_gen2.

Verification
REQ-034 Reset, then write 1..16 with WREN=1, DEPTH=16 -> full=1, count=16, almost_full set at count=14, overflow=0.
REQ-035 From full, read 16 times -> data_out 1..16 in order, each one cycle after RDEN; empty=1 and almost_empty set at count=2.
REQ-036 Full FIFO, WREN=RDEN=1 with data_in=99 for 1 cycle -> count stays 16, full stays 1, and 99 is read out last.
REQ-037 Empty FIFO, WREN=RDEN=1 with data_in=7 -> count=1, underflow=0, and the next read returns 7.
REQ-038 Full FIFO, WREN only -> overflow=1 and sticky, contents unchanged; pulse clr_err -> overflow=0.
REQ-039 Write 5 entries, drop rst low mid-cycle -> all outputs reach reset values immediately; after release, write 42 and read -> data_out=42.
